// File: rtl/ui_mode_ctrl_pkg.sv
// Shared types, indices, field widths and wrap helpers for the front-panel
// mode controller.
package ui_ctrl_pkg;

  typedef enum logic [2:0] {
    StTop       = 3'd0,
    StSigEdit   = 3'd1,
    StSigCommit = 3'd2,
    StSigRun    = 3'd3,
    StOsiTime   = 3'd4,
    StOsiFft    = 3'd5,
    StLoa       = 3'd6
  } state_t;

  localparam int unsigned ModeW = 2;
  localparam int unsigned SelW  = 2;
  localparam int unsigned RowW  = 3;
  localparam int unsigned ParW  = 2;
  localparam int unsigned ZoomW = 2;
  localparam int unsigned DispW = RowW + 4 * ParW;

  localparam logic [ModeW-1:0] ModeTop = 2'd0;
  localparam logic [ModeW-1:0] ModeSig = 2'd1;
  localparam logic [ModeW-1:0] ModeOsi = 2'd2;
  localparam logic [ModeW-1:0] ModeLoa = 2'd3;

  localparam logic [SelW-1:0] TopSig = 2'd0;
  localparam logic [SelW-1:0] TopOsi = 2'd1;
  localparam logic [SelW-1:0] TopLoa = 2'd2;

  localparam logic [RowW-1:0] RowWave  = 3'd0;
  localparam logic [RowW-1:0] RowAmp   = 3'd1;
  localparam logic [RowW-1:0] RowFre   = 3'd2;
  localparam logic [RowW-1:0] RowPhase = 3'd3;
  localparam logic [RowW-1:0] RowApply = 3'd4;

  localparam int unsigned DispPhaseLsb = 0;
  localparam int unsigned DispFreLsb   = DispPhaseLsb + ParW;
  localparam int unsigned DispAmpLsb   = DispFreLsb + ParW;
  localparam int unsigned DispWaveLsb  = DispAmpLsb + ParW;
  localparam int unsigned DispRowLsb   = DispWaveLsb + ParW;

  localparam int unsigned EvW       = 6;
  localparam int unsigned EvRight   = 0;
  localparam int unsigned EvLeft    = 1;
  localparam int unsigned EvDown    = 2;
  localparam int unsigned EvUp      = 3;
  localparam int unsigned EvConfirm = 4;
  localparam int unsigned EvQuit    = 5;

  function automatic logic [1:0] wrap_inc2(input logic [1:0] v, input logic [1:0] max);
    return (v == max) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec2(input logic [1:0] v, input logic [1:0] max);
    return (v == 2'd0) ? max : v - 2'd1;
  endfunction

  function automatic logic [2:0] wrap_inc3(input logic [2:0] v, input logic [2:0] max);
    return (v == max) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec3(input logic [2:0] v, input logic [2:0] max);
    return (v == 3'd0) ? max : v - 3'd1;
  endfunction

endpackage

// File: rtl/ui_mode_ctrl_if.sv
// Configuration commit bundle between the mode controller and sig_gen.
interface ui_mode_ctrl_if;
  import ui_ctrl_pkg::*;

  logic            sig_cfg_valid;
  logic            sig_cfg_ready;
  logic [ParW-1:0] sig_wave;
  logic [ParW-1:0] sig_amp;
  logic [ParW-1:0] sig_fre;
  logic [ParW-1:0] sig_phase;

  modport master (
    output sig_cfg_valid, sig_wave, sig_amp, sig_fre, sig_phase,
    input  sig_cfg_ready
  );

  modport slave (
    input  sig_cfg_valid, sig_wave, sig_amp, sig_fre, sig_phase,
    output sig_cfg_ready
  );

endinterface

// File: rtl/ui_mode_ctrl_evt_prio.sv
// Reduces simultaneous button pulses to a single one-hot event,
// quit > confirm > up > down > left > right.
module ui_evt_prio
  import ui_ctrl_pkg::*;
(
  input  logic           btn_quit_i,
  input  logic           btn_confirm_i,
  input  logic           btn_up_i,
  input  logic           btn_down_i,
  input  logic           btn_left_i,
  input  logic           btn_right_i,
  output logic [EvW-1:0] evt_o
);

  always_comb begin
    evt_o = '0;
    if (btn_quit_i)         evt_o[EvQuit]    = 1'b1;
    else if (btn_confirm_i) evt_o[EvConfirm] = 1'b1;
    else if (btn_up_i)      evt_o[EvUp]      = 1'b1;
    else if (btn_down_i)    evt_o[EvDown]    = 1'b1;
    else if (btn_left_i)    evt_o[EvLeft]    = 1'b1;
    else if (btn_right_i)   evt_o[EvRight]   = 1'b1;
  end

endmodule

// File: rtl/ui_mode_ctrl.sv
// Front-panel menu FSM: owns user parameters, sequences the sig_gen commit
// handshake with a watchdog, and drives datapath enables and display cursor.
module ui_mode_ctrl
  import ui_ctrl_pkg::*;
#(
  parameter int unsigned N_TOP          = 3,
  parameter int unsigned N_SIG_ROWS     = 5,
  parameter int unsigned ZOOM_MAX       = 2,
  parameter int unsigned COMMIT_TIMEOUT = 1024
) (
  input  logic               clk_50M,
  input  logic               rst,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_confirm,
  input  logic               btn_quit,
  ui_mode_ctrl_if.master     cfg_if,
  output logic [ModeW-1:0]   mode,
  output logic               level,
  output logic [SelW-1:0]    top_sel,
  output logic [RowW-1:0]    sig_row,
  output logic               sig_run,
  output logic               cfg_timeout,
  output logic               osc_en,
  output logic               fft_en,
  output logic [ZoomW-1:0]   v_zoom,
  output logic [ZoomW-1:0]   h_zoom,
  output logic               la_en,
  output logic [DispW-1:0]   disp_cfg
);

  localparam int unsigned      CntW     = $clog2(COMMIT_TIMEOUT);
  localparam logic [CntW-1:0]  CntLast  = CntW'(COMMIT_TIMEOUT - 1);
  localparam logic [SelW-1:0]  TopMax   = SelW'(N_TOP - 1);
  localparam logic [RowW-1:0]  RowMax   = RowW'(N_SIG_ROWS - 1);
  localparam logic [ZoomW-1:0] ZoomMax  = ZoomW'(ZOOM_MAX);
  localparam logic [ParW-1:0]  ParMax   = '1;

  logic [EvW-1:0] evt;

  ui_evt_prio u_evt_prio (
    .btn_quit_i    (btn_quit),
    .btn_confirm_i (btn_confirm),
    .btn_up_i      (btn_up),
    .btn_down_i    (btn_down),
    .btn_left_i    (btn_left),
    .btn_right_i   (btn_right),
    .evt_o         (evt)
  );

  state_t                state_q, state_d;
  logic [SelW-1:0]       top_sel_q, top_sel_d;
  logic [RowW-1:0]       sig_row_q, sig_row_d;
  logic [3:0][ParW-1:0]  par_q, par_d;
  logic                  run_q, run_d;
  logic                  timeout_q, timeout_d;
  logic [ZoomW-1:0]      vz_q, vz_d;
  logic [ZoomW-1:0]      hz_q, hz_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ModeW-1:0]      mode_q, mode_d;
  logic                  level_q, level_d;
  logic                  valid_q, valid_d;
  logic                  osc_q, osc_d;
  logic                  fft_q, fft_d;
  logic                  la_q, la_d;
  logic                  clr_sig;

  always_comb begin
    state_d   = state_q;
    top_sel_d = top_sel_q;
    sig_row_d = sig_row_q;
    par_d     = par_q;
    run_d     = run_q;
    vz_d      = vz_q;
    hz_d      = hz_q;
    timeout_d = 1'b0;
    cnt_d     = '0;
    clr_sig   = 1'b0;

    case (state_q)
      StTop: begin
        if (evt[EvConfirm]) begin
          case (top_sel_q)
            TopSig:  state_d = StSigEdit;
            TopOsi:  state_d = StOsiTime;
            TopLoa:  state_d = StLoa;
            default: state_d = StTop;
          endcase
        end else if (evt[EvLeft]) begin
          top_sel_d = wrap_dec2(top_sel_q, TopMax);
        end else if (evt[EvRight]) begin
          top_sel_d = wrap_inc2(top_sel_q, TopMax);
        end
      end
      StSigEdit: begin
        if (evt[EvQuit]) begin
          state_d = StTop;
          clr_sig = 1'b1;
        end else if (evt[EvConfirm]) begin
          if (sig_row_q == RowApply) state_d = StSigCommit;
        end else if (evt[EvUp]) begin
          sig_row_d = wrap_dec3(sig_row_q, RowMax);
        end else if (evt[EvDown]) begin
          sig_row_d = wrap_inc3(sig_row_q, RowMax);
        end else if (sig_row_q != RowApply) begin
          if (evt[EvLeft]) begin
            par_d[sig_row_q[1:0]] = wrap_dec2(par_q[sig_row_q[1:0]], ParMax);
          end else if (evt[EvRight]) begin
            par_d[sig_row_q[1:0]] = wrap_inc2(par_q[sig_row_q[1:0]], ParMax);
          end
        end
      end
      StSigCommit: begin
        // valid is known high here, so ready alone completes the transfer.
        if (evt[EvQuit]) begin
          state_d = StSigEdit;
        end else if (cfg_if.sig_cfg_ready) begin
          state_d = StSigRun;
          run_d   = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d   = StSigEdit;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSigRun: begin
        if (evt[EvQuit]) begin
          state_d = StTop;
          clr_sig = 1'b1;
        end else if (evt[EvConfirm]) begin
          state_d = StSigEdit;
        end
      end
      StOsiTime: begin
        if (evt[EvQuit]) begin
          state_d = StTop;
          vz_d    = '0;
          hz_d    = '0;
        end else if (evt[EvConfirm]) begin
          state_d = StOsiFft;
        end else if (evt[EvUp]) begin
          vz_d = wrap_inc2(vz_q, ZoomMax);
        end else if (evt[EvDown]) begin
          vz_d = wrap_dec2(vz_q, ZoomMax);
        end else if (evt[EvLeft]) begin
          hz_d = wrap_dec2(hz_q, ZoomMax);
        end else if (evt[EvRight]) begin
          hz_d = wrap_inc2(hz_q, ZoomMax);
        end
      end
      StOsiFft: begin
        if (evt[EvQuit]) state_d = StOsiTime;
      end
      StLoa: begin
        if (evt[EvQuit]) state_d = StTop;
      end
      default: begin
        state_d = StTop;
        clr_sig = 1'b1;
        vz_d    = '0;
        hz_d    = '0;
      end
    endcase

    if (clr_sig) begin
      top_sel_d = '0;
      sig_row_d = '0;
      par_d     = '0;
      run_d     = 1'b0;
    end

    // Enables are decoded from the next state so they stay registered.
    mode_d  = ModeTop;
    level_d = (state_d != StTop);
    valid_d = 1'b0;
    osc_d   = 1'b0;
    fft_d   = 1'b0;
    la_d    = 1'b0;
    case (state_d)
      StSigEdit, StSigRun: mode_d = ModeSig;
      StSigCommit: begin
        mode_d  = ModeSig;
        valid_d = 1'b1;
      end
      StOsiTime: begin
        mode_d = ModeOsi;
        osc_d  = 1'b1;
      end
      StOsiFft: begin
        mode_d = ModeOsi;
        osc_d  = 1'b1;
        fft_d  = 1'b1;
      end
      StLoa: begin
        mode_d = ModeLoa;
        la_d   = 1'b1;
      end
      default: mode_d = ModeTop;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q   <= StTop;
      top_sel_q <= '0;
      sig_row_q <= '0;
      par_q     <= '0;
      run_q     <= 1'b0;
      timeout_q <= 1'b0;
      vz_q      <= '0;
      hz_q      <= '0;
      cnt_q     <= '0;
      mode_q    <= ModeTop;
      level_q   <= 1'b0;
      valid_q   <= 1'b0;
      osc_q     <= 1'b0;
      fft_q     <= 1'b0;
      la_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      top_sel_q <= top_sel_d;
      sig_row_q <= sig_row_d;
      par_q     <= par_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      vz_q      <= vz_d;
      hz_q      <= hz_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      osc_q     <= osc_d;
      fft_q     <= fft_d;
      la_q      <= la_d;
    end
  end

  assign cfg_if.sig_cfg_valid = valid_q;
  assign cfg_if.sig_wave      = par_q[0];
  assign cfg_if.sig_amp       = par_q[1];
  assign cfg_if.sig_fre       = par_q[2];
  assign cfg_if.sig_phase     = par_q[3];

  assign mode        = mode_q;
  assign level       = level_q;
  assign top_sel     = top_sel_q;
  assign sig_row     = sig_row_q;
  assign sig_run     = run_q;
  assign cfg_timeout = timeout_q;
  assign osc_en      = osc_q;
  assign fft_en      = fft_q;
  assign v_zoom      = vz_q;
  assign h_zoom      = hz_q;
  assign la_en       = la_q;

  assign disp_cfg[DispRowLsb   +: RowW] = sig_row_q;
  assign disp_cfg[DispWaveLsb  +: ParW] = par_q[0];
  assign disp_cfg[DispAmpLsb   +: ParW] = par_q[1];
  assign disp_cfg[DispFreLsb   +: ParW] = par_q[2];
  assign disp_cfg[DispPhaseLsb +: ParW] = par_q[3];

endmodule

// File: tb/tb_ui_mode_ctrl.sv
// Directed scenarios plus random button/ready traffic against a menu-level
// reference model of the front-panel controller.
module tb_ui_mode_ctrl;

  localparam logic [5:0] BQ = 6'b100000;
  localparam logic [5:0] BC = 6'b010000;
  localparam logic [5:0] BU = 6'b001000;
  localparam logic [5:0] BD = 6'b000100;
  localparam logic [5:0] BL = 6'b000010;
  localparam logic [5:0] BR = 6'b000001;
  localparam int TIMEOUT = 1024;

  logic clk_50M = 1'b0;
  logic rst = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
  logic btn_down = 1'b0, btn_confirm = 1'b0, btn_quit = 1'b0;
  logic [1:0]  mode, top_sel, v_zoom, h_zoom;
  logic [2:0]  sig_row;
  logic        level, sig_run, cfg_timeout, osc_en, fft_en, la_en;
  logic [10:0] disp_cfg;

  ui_mode_ctrl_if cfg_if ();

  ui_mode_ctrl dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_confirm (btn_confirm),
    .btn_quit    (btn_quit),
    .cfg_if      (cfg_if),
    .mode        (mode),
    .level       (level),
    .top_sel     (top_sel),
    .sig_row     (sig_row),
    .sig_run     (sig_run),
    .cfg_timeout (cfg_timeout),
    .osc_en      (osc_en),
    .fft_en      (fft_en),
    .v_zoom      (v_zoom),
    .h_zoom      (h_zoom),
    .la_en       (la_en),
    .disp_cfg    (disp_cfg)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;

  // Menu model: 0 top, 1 edit, 2 commit, 3 run, 4 osc time, 5 fft, 6 logic analyser.
  int m_st, m_top, m_row, m_run, m_to, m_vz, m_hz, m_wait;
  int m_par[4];

  task automatic model_reset();
    m_st = 0; m_top = 0; m_row = 0; m_run = 0; m_to = 0; m_vz = 0; m_hz = 0; m_wait = 0;
    for (int i = 0; i < 4; i++) m_par[i] = 0;
  endtask

  task automatic model_clear_sig();
    m_st = 0; m_top = 0; m_row = 0; m_run = 0;
    for (int i = 0; i < 4; i++) m_par[i] = 0;
  endtask

  // Event code: 0 quit, 1 confirm, 2 up, 3 down, 4 left, 5 right, -1 none.
  task automatic model_step(input logic [5:0] b, input logic rdy);
    int ev;
    ev = -1;
    for (int i = 0; i < 6; i++) if (ev < 0 && b[5-i]) ev = i;
    m_to = 0;
    case (m_st)
      0: begin
        if (ev == 1) m_st = (m_top == 0) ? 1 : (m_top == 1) ? 4 : 6;
        else if (ev == 4) m_top = (m_top + 2) % 3;
        else if (ev == 5) m_top = (m_top + 1) % 3;
      end
      1: begin
        if (ev == 0) model_clear_sig();
        else if (ev == 1 && m_row == 4) begin m_st = 2; m_wait = 0; end
        else if (ev == 2) m_row = (m_row + 4) % 5;
        else if (ev == 3) m_row = (m_row + 1) % 5;
        else if (ev == 4 && m_row < 4) m_par[m_row] = (m_par[m_row] + 3) % 4;
        else if (ev == 5 && m_row < 4) m_par[m_row] = (m_par[m_row] + 1) % 4;
      end
      2: begin
        m_wait++;
        if (ev == 0) m_st = 1;
        else if (rdy) begin m_st = 3; m_run = 1; end
        else if (m_wait == TIMEOUT) begin m_st = 1; m_to = 1; end
      end
      3: begin
        if (ev == 0) model_clear_sig();
        else if (ev == 1) m_st = 1;
      end
      4: begin
        if (ev == 0) begin m_st = 0; m_vz = 0; m_hz = 0; end
        else if (ev == 1) m_st = 5;
        else if (ev == 2) m_vz = (m_vz + 1) % 3;
        else if (ev == 3) m_vz = (m_vz + 2) % 3;
        else if (ev == 4) m_hz = (m_hz + 2) % 3;
        else if (ev == 5) m_hz = (m_hz + 1) % 3;
      end
      5: if (ev == 0) m_st = 4;
      6: if (ev == 0) m_st = 0;
      default: m_st = 0;
    endcase
  endtask

  function automatic logic [36:0] model_vec();
    logic [1:0]  md;
    logic [10:0] disp;
    md = (m_st == 0) ? 2'd0 : (m_st <= 3) ? 2'd1 : (m_st <= 5) ? 2'd2 : 2'd3;
    disp = {3'(m_row), 2'(m_par[0]), 2'(m_par[1]), 2'(m_par[2]), 2'(m_par[3])};
    return {md, 1'(m_st != 0), 2'(m_top), 3'(m_row), 2'(m_par[0]), 2'(m_par[1]),
            2'(m_par[2]), 2'(m_par[3]), 1'(m_st == 2), 1'(m_run), 1'(m_to),
            1'(m_st == 4 || m_st == 5), 1'(m_st == 5), 2'(m_vz), 2'(m_hz),
            1'(m_st == 6), disp};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {mode, level, top_sel, sig_row, cfg_if.sig_wave, cfg_if.sig_amp, cfg_if.sig_fre,
            cfg_if.sig_phase, cfg_if.sig_cfg_valid, sig_run, cfg_timeout, osc_en, fft_en,
            v_zoom, h_zoom, la_en, disp_cfg};
  endfunction

  task automatic step(input logic [5:0] b, input logic rdy, input logic r);
    {btn_quit, btn_confirm, btn_up, btn_down, btn_left, btn_right} = b;
    cfg_if.sig_cfg_ready = rdy;
    rst = r;
    @(posedge clk_50M);
    if (r) model_reset();
    else model_step(b, rdy);
    #1;
    {btn_quit, btn_confirm, btn_up, btn_down, btn_left, btn_right} = '0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 37'd0) begin
      errors++; $display("FAIL reset_zero: got %h exp %h", dut_vec(), 37'd0);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_model: got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_top_nav();
    logic [1:0] exp_r[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [1:0] exp_l[2] = '{2'd0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      step(BR, 1'b0, 1'b0);
      checks++;
      if (top_sel !== exp_r[i]) begin
        errors++; $display("FAIL top_right[%0d]: got %0d exp %0d", i, top_sel, exp_r[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(BL, 1'b0, 1'b0);
      checks++;
      if (top_sel !== exp_l[i]) begin
        errors++; $display("FAIL top_left[%0d]: got %0d exp %0d", i, top_sel, exp_l[i]);
      end
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL top_model: got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_sig_edit();
    logic [5:0] seq[9] = '{BR, BC, BR, BD, BR, BR, BD, BD, BD};
    logic [2:0] exp_up[5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
    foreach (seq[i]) step(seq[i], 1'b0, 1'b0);
    checks++;
    if ({mode, cfg_if.sig_wave, cfg_if.sig_amp, sig_row} !== {2'd1, 2'd1, 2'd2, 3'd4}) begin
      errors++;
      $display("FAIL edit_params: got mode %0d wave %0d amp %0d row %0d exp 1 1 2 4",
               mode, cfg_if.sig_wave, cfg_if.sig_amp, sig_row);
    end
    checks++;
    if (disp_cfg !== 11'b100_01_10_00_00) begin
      errors++; $display("FAIL edit_disp: got %b exp %b", disp_cfg, 11'b100_01_10_00_00);
    end
    for (int i = 0; i < 5; i++) begin
      step(BU, 1'b0, 1'b0);
      checks++;
      if (sig_row !== exp_up[i]) begin
        errors++; $display("FAIL edit_up[%0d]: got %0d exp %0d", i, sig_row, exp_up[i]);
      end
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL edit_model: got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_commit();
    step(BC, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      checks++;
      if (cfg_if.sig_cfg_valid !== 1'b1 || sig_run !== 1'b0) begin
        errors++;
        $display("FAIL commit_wait[%0d]: got valid %b run %b exp 1 0",
                 i, cfg_if.sig_cfg_valid, sig_run);
      end
      step('0, (i == 11), 1'b0);
    end
    checks++;
    if ({cfg_if.sig_cfg_valid, sig_run, mode} !== {1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL commit_xfer: got valid %b run %b mode %0d exp 0 1 1",
               cfg_if.sig_cfg_valid, sig_run, mode);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL commit_model: got %h exp %h", dut_vec(), model_vec());
    end
    step(BL, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || cfg_if.sig_wave !== 2'd1) begin
      errors++; $display("FAIL run_ignore: got %h exp %h", dut_vec(), model_vec());
    end
    step(BQ, 1'b0, 1'b0);
    checks++;
    if ({mode, sig_run, disp_cfg, top_sel} !== 16'd0) begin
      errors++;
      $display("FAIL run_quit: got mode %0d run %b disp %h top %0d exp all 0",
               mode, sig_run, disp_cfg, top_sel);
    end
  endtask

  task automatic test_timeout();
    int vcnt, tcnt, n;
    logic [5:0] seq[5] = '{BC, BR, BR, BR, BU};
    foreach (seq[i]) step(seq[i], 1'b0, 1'b0);
    step(BC, 1'b0, 1'b0);
    vcnt = 0; tcnt = 0; n = 0;
    while (cfg_if.sig_cfg_valid === 1'b1 && n < 1100) begin
      vcnt++;
      step('0, 1'b0, 1'b0);
      n++;
      if (cfg_timeout === 1'b1) tcnt++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL timeout_model[%0d]: got %h exp %h", n, dut_vec(), model_vec());
      end
    end
    checks++;
    if (vcnt !== TIMEOUT || tcnt !== 1) begin
      errors++;
      $display("FAIL timeout_len: got valid %0d pulses %0d exp %0d 1", vcnt, tcnt, TIMEOUT);
    end
    checks++;
    if ({mode, sig_row, cfg_if.sig_wave, sig_run} !== {2'd1, 3'd4, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL timeout_state: got mode %0d row %0d wave %0d run %b exp 1 4 3 0",
               mode, sig_row, cfg_if.sig_wave, sig_run);
    end
    step('0, 1'b0, 1'b0);
    checks++;
    if (cfg_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got %b exp 0", cfg_timeout);
    end
  endtask

  task automatic test_osi();
    logic [1:0] exp_v[3] = '{2'd1, 2'd2, 2'd0};
    step(BQ, 1'b0, 1'b0);
    step(BR, 1'b0, 1'b0);
    step(BC, 1'b0, 1'b0);
    checks++;
    if ({mode, osc_en, fft_en} !== {2'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL osi_entry: got mode %0d osc %b fft %b exp 2 1 0",
                         mode, osc_en, fft_en);
    end
    for (int i = 0; i < 3; i++) begin
      step(BU, 1'b0, 1'b0);
      checks++;
      if (v_zoom !== exp_v[i]) begin
        errors++; $display("FAIL osi_vz[%0d]: got %0d exp %0d", i, v_zoom, exp_v[i]);
      end
    end
    step(BL, 1'b0, 1'b0);
    checks++;
    if (h_zoom !== 2'd2) begin
      errors++; $display("FAIL osi_hz: got %0d exp 2", h_zoom);
    end
    step(BC, 1'b0, 1'b0);
    step(BU, 1'b0, 1'b0);
    checks++;
    if ({fft_en, osc_en, v_zoom} !== {1'b1, 1'b1, 2'd0}) begin
      errors++; $display("FAIL fft_hold: got fft %b osc %b vz %0d exp 1 1 0",
                         fft_en, osc_en, v_zoom);
    end
    step(BQ, 1'b0, 1'b0);
    checks++;
    if ({fft_en, h_zoom, mode} !== {1'b0, 2'd2, 2'd2}) begin
      errors++; $display("FAIL fft_quit: got fft %b hz %0d mode %0d exp 0 2 2",
                         fft_en, h_zoom, mode);
    end
    step(BQ, 1'b0, 1'b0);
    checks++;
    if ({mode, v_zoom, h_zoom, osc_en} !== 7'd0) begin
      errors++; $display("FAIL osi_quit: got mode %0d vz %0d hz %0d osc %b exp 0",
                         mode, v_zoom, h_zoom, osc_en);
    end
  endtask

  task automatic test_priority_reset();
    step(BL, 1'b0, 1'b0);
    step(BC, 1'b0, 1'b0);
    step(BR, 1'b0, 1'b0);
    step(BQ | BC | BR, 1'b0, 1'b0);
    checks++;
    if ({mode, top_sel, cfg_if.sig_wave} !== 6'd0) begin
      errors++; $display("FAIL prio_quit: got mode %0d top %0d wave %0d exp 0 0 0",
                         mode, top_sel, cfg_if.sig_wave);
    end
    step(BC, 1'b0, 1'b0);
    step(BU, 1'b0, 1'b0);
    step(BC, 1'b0, 1'b0);
    checks++;
    if (cfg_if.sig_cfg_valid !== 1'b1) begin
      errors++; $display("FAIL prio_commit: got valid %b exp 1", cfg_if.sig_cfg_valid);
    end
    step('0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 37'd0) begin
      errors++; $display("FAIL commit_reset: got %h exp 0", dut_vec());
    end
  endtask

  task automatic test_random();
    logic [5:0] b;
    logic rdy, r;
    for (int i = 0; i < 1500; i++) begin
      b   = 6'($urandom) & 6'($urandom);
      rdy = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 299) == 0);
      step(b, rdy, r);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    cfg_if.sig_cfg_ready = 1'b0;
    model_reset();
    @(negedge clk_50M);
    test_reset();
    test_top_nav();
    test_sig_edit();
    test_commit();
    test_timeout();
    test_osi();
    test_priority_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
